// File: rtl/aurora_status_pkg.sv
// Shared definitions for the Aurora link status monitor: link state encoding,
// default 33 MHz timing constants and the drop counter width.
package aurora_status_pkg;

  localparam int unsigned LINK_STATE_W = 2;
  localparam int unsigned DROP_CNT_W   = 8;

  // ~31.8 ms of stable channel_up and ~2 ms of holdoff at 33 MHz
  localparam int unsigned QUAL_CYCLES_33M    = 1048576;
  localparam int unsigned HOLDOFF_CYCLES_33M = 65536;

  typedef enum logic [LINK_STATE_W-1:0] {
    LS_DOWN    = 2'b00,
    LS_QUAL    = 2'b01,
    LS_UP      = 2'b10,
    LS_HOLDOFF = 2'b11
  } link_state_t;

endpackage : aurora_status_pkg

// File: rtl/aurora_link_status_monitor_activity_stretcher.sv
// Retriggerable pulse stretcher: turns a single-cycle strobe into an activity
// level of at least STRETCH_CYCLES cycles while enabled; clears when disabled.
module activity_stretcher #(
  parameter int unsigned STRETCH_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic strobe,
  output logic act
);

  localparam int unsigned SW = $clog2(STRETCH_CYCLES + 1);

  logic [SW-1:0] cnt;
  logic [SW-1:0] cnt_nxt;

  // Reload on an accepted strobe, otherwise count down to zero
  always_comb begin
    cnt_nxt = cnt;
    if (!enable) begin
      cnt_nxt = '0;
    end else if (strobe) begin
      cnt_nxt = SW'(STRETCH_CYCLES);
    end else if (cnt != '0) begin
      cnt_nxt = cnt - SW'(1);
    end
  end

  // Counter and registered activity level move on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      act <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      act <= (cnt_nxt != '0);
    end
  end

endmodule : activity_stretcher

// File: rtl/aurora_link_status_monitor.sv
// Aurora link status monitor: qualifies asynchronous channel_up into a stable
// rdy level and stretches FIFO write/read strobes into LED activity levels.
// Optional feature macro: LINK_MON_DROP_CNT_EN builds the saturating drop_cnt
// register; without it drop_cnt is tied to zero.
module aurora_link_status_monitor
  import aurora_status_pkg::*;
#(
  parameter int unsigned QUAL_CYCLES    = QUAL_CYCLES_33M,
  parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_CYCLES_33M,
  parameter int unsigned STRETCH_CYCLES = 8,
  parameter int unsigned CNT_W          = 21
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    channel_up,
  input  logic                    wr_strobe,
  input  logic                    rd_strobe,
  output logic                    rdy,
  output logic                    wr_act,
  output logic                    rd_act,
  output logic [LINK_STATE_W-1:0] link_state,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  localparam logic [CNT_W-1:0] QUAL_LAST    = CNT_W'(QUAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  logic        chup_meta;
  logic        chup_s;

  link_state_t state;
  link_state_t state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic rdy_nxt;
  logic act_en_c;

  // Two-flop synchroniser for channel_up from the Aurora user-clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chup_meta <= 1'b0;
      chup_s    <= 1'b0;
    end else begin
      chup_meta <= channel_up;
      chup_s    <= chup_meta;
    end
  end

  // State register with the shared qualification/holdoff counter and rdy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LS_DOWN;
      cnt   <= '0;
      rdy   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rdy   <= rdy_nxt;
    end
  end

  // Next-state logic: DOWN -> QUAL -> UP -> HOLDOFF -> DOWN
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      LS_DOWN: begin
        if (chup_s) begin
          state_nxt = LS_QUAL;
          cnt_nxt   = '0;
        end
      end
      LS_QUAL: begin
        if (!chup_s) begin
          state_nxt = LS_DOWN;
        end else if (cnt == QUAL_LAST) begin
          state_nxt = LS_UP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      LS_UP: begin
        if (!chup_s) begin
          state_nxt = LS_HOLDOFF;
          cnt_nxt   = '0;
        end
      end
      LS_HOLDOFF: begin
        // Link flaps during holdoff are deliberately ignored
        if (cnt == HOLDOFF_LAST) begin
          state_nxt = LS_DOWN;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = LS_DOWN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode: rdy tracks the UP state; strobes only count while UP holds
  always_comb begin
    rdy_nxt  = (state_nxt == LS_UP);
    act_en_c = (state == LS_UP) && (state_nxt == LS_UP);
  end

  assign link_state = state;

  activity_stretcher #(
    .STRETCH_CYCLES(STRETCH_CYCLES)
  ) u_wr_stretch (
    .clk   (clk),
    .rst   (rst),
    .enable(act_en_c),
    .strobe(wr_strobe),
    .act   (wr_act)
  );

  activity_stretcher #(
    .STRETCH_CYCLES(STRETCH_CYCLES)
  ) u_rd_stretch (
    .clk   (clk),
    .rst   (rst),
    .enable(act_en_c),
    .strobe(rd_strobe),
    .act   (rd_act)
  );

`ifdef LINK_MON_DROP_CNT_EN
  logic                  drop_evt_c;
  logic [DROP_CNT_W-1:0] drop_q;

  assign drop_evt_c = (state == LS_UP) && (state_nxt == LS_HOLDOFF);

  // Saturating count of link drops out of UP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop_evt_c && (drop_q != '1)) begin
      drop_q <= drop_q + DROP_CNT_W'(1);
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule : aurora_link_status_monitor

// File: tb/tb_aurora_link_status_monitor.sv
// Testbench for aurora_link_status_monitor: directed and randomized stimulus
// checked cycle by cycle against a timeline-based reference model.
module tb_aurora_link_status_monitor;

  localparam int unsigned Q = 16;
  localparam int unsigned H = 8;
  localparam int unsigned S = 4;
`ifdef LINK_MON_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       channel_up;
  logic       wr_strobe;
  logic       rd_strobe;
  logic       rdy;
  logic       wr_act;
  logic       rd_act;
  logic [1:0] link_state;
  logic [7:0] drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: sync pipeline, run length of stable link, holdoff timer,
  // activity end times on an absolute cycle timeline
  bit m_s1, m_s2, m_up;
  int m_run, m_hold, m_n, m_wr_until, m_rd_until, m_drops;

  aurora_link_status_monitor #(
    .QUAL_CYCLES   (Q),
    .HOLDOFF_CYCLES(H),
    .STRETCH_CYCLES(S),
    .CNT_W         (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .channel_up(channel_up),
    .wr_strobe (wr_strobe),
    .rd_strobe (rd_strobe),
    .rdy       (rdy),
    .wr_act    (wr_act),
    .rd_act    (rd_act),
    .link_state(link_state),
    .drop_cnt  (drop_cnt)
  );

  always #15 clk = ~clk;

  function automatic void model_reset();
    m_s1 = 0; m_s2 = 0; m_up = 0;
    m_run = 0; m_hold = 0; m_wr_until = 0; m_rd_until = 0; m_drops = 0;
  endfunction

  function automatic void model_edge(bit cu, bit ws, bit rs);
    bit c;
    bit was_up;
    c = m_s2;
    was_up = m_up;
    m_n++;
    m_s2 = m_s1;
    m_s1 = cu;
    if (m_hold > 0) begin
      m_hold--;
    end else if (m_up) begin
      if (!c) begin
        m_up = 0;
        m_hold = H;
        if (DROP_EN && m_drops < 255) m_drops++;
      end
    end else begin
      // Link goes up after Q+1 consecutive synchronised-high samples
      m_run = c ? m_run + 1 : 0;
      if (m_run == Q + 1) begin
        m_up = 1;
        m_run = 0;
      end
    end
    if (was_up && m_up) begin
      if (ws) m_wr_until = m_n + S;
      if (rs) m_rd_until = m_n + S;
    end
    if (!m_up) begin
      m_wr_until = 0;
      m_rd_until = 0;
    end
  endfunction

  function automatic logic [31:0] exp_state();
    if (m_hold > 0) return 32'd3;
    if (m_up) return 32'd2;
    if (m_run > 0) return 32'd1;
    return 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, m_n, got, exp);
    end
  endtask

  task automatic check_all();
    chk("rdy", 32'(rdy), 32'(m_up));
    chk("link_state", 32'(link_state), exp_state());
    chk("wr_act", 32'(wr_act), 32'(m_n < m_wr_until));
    chk("rd_act", 32'(rd_act), 32'(m_n < m_rd_until));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
  endtask

  task automatic step(input bit cu, input bit ws, input bit rs);
    channel_up = cu;
    wr_strobe  = ws;
    rd_strobe  = rs;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(cu, ws, rs);
    #1;
    check_all();
  endtask

  initial begin
    int qual_at, rdy_at, hold_len, len;
    bit run_on, cu;

    // Reset
    m_n = 0;
    model_reset();
    rst = 1'b1;
    channel_up = 1'b0;
    wr_strobe = 1'b0;
    rd_strobe = 1'b0;
    #1;
    chk("reset_rdy", 32'(rdy), 32'd0);
    chk("reset_state", 32'(link_state), 32'd0);
    step(0, 0, 0);
    step(0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0);

    // Qualification from a clean channel_up edge
    qual_at = 0;
    rdy_at = 0;
    for (int k = 1; k <= 25; k++) begin
      step(1, 0, 0);
      if (link_state == 2'b01 && qual_at == 0) qual_at = k;
      if (rdy && rdy_at == 0) rdy_at = k;
    end
    chk("qual_entry_step", 32'(qual_at), 32'd3);
    chk("rdy_rise_step", 32'(rdy_at), 32'd19);

    // Link drop: holdoff lasts H cycles even when channel_up returns at once
    step(0, 0, 0);
    hold_len = 0;
    for (int k = 0; k < 40; k++) begin
      step(1, 0, 0);
      if (link_state == 2'b11) hold_len++;
    end
    chk("holdoff_len", 32'(hold_len), 32'(H));

    // Dropout during QUAL at cnt=10 returns to DOWN and forces full requalification
    for (int k = 0; k < 12; k++) step(0, 0, 0);
    for (int k = 0; k < 13; k++) step(1, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 1);
    rdy_at = 0;
    for (int k = 1; k <= 25; k++) begin
      step(1, 0, 0);
      if (rdy && rdy_at == 0) rdy_at = k;
    end
    chk("requal_rdy_step", 32'(rdy_at), 32'd19);

    // Single write strobe
    step(1, 1, 0);
    len = 0;
    for (int i = 0; i < 10; i++) begin
      if (wr_act) len++;
      step(1, 0, 0);
    end
    chk("wr_stretch_len", 32'(len), 32'(S));

    // Retrigger during the third active cycle keeps the level continuous
    step(1, 1, 0);
    len = 0;
    run_on = 1;
    for (int i = 0; i < 15; i++) begin
      if (wr_act && run_on) len++;
      else run_on = 0;
      step(1, i == 2, 0);
    end
    chk("wr_retrigger_len", 32'(len), 32'(S + 3));

    // Simultaneous strobes
    step(1, 1, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0);

    // Drop with activity high: act falls on the same edge as rdy
    step(1, 1, 1);
    step(0, 1, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("drop_rdy_low", 32'(rdy), 32'd0);
    chk("drop_wr_act_low", 32'(wr_act), 32'd0);
    chk("drop_rd_act_low", 32'(rd_act), 32'd0);

    // Strobes outside UP (holdoff, down, qual) must not produce activity
    for (int i = 0; i < 30; i++) step(i > 12, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Randomized sticky link with random strobes
    cu = 1;
    for (int i = 0; i < 2000; i++) begin
      if (cu && $urandom_range(0, 39) == 0) cu = 0;
      else if (!cu && $urandom_range(0, 7) == 0) cu = 1;
      step(cu, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    // Many link drops to reach drop counter saturation
    for (int i = 0; i < 30; i++) step(1, 0, 0);
    for (int d = 0; d < 300; d++) begin
      for (int k = 0; k < 3; k++) step(0, $urandom_range(0, 3) == 0, 0);
      for (int k = 0; k < 32; k++) step(1, 0, $urandom_range(0, 3) == 0);
    end
    chk("drop_cnt_final", 32'(drop_cnt), DROP_EN ? 32'd255 : 32'd0);

    // Asynchronous reset in the middle of QUAL
    for (int k = 0; k < 12; k++) step(0, 0, 0);
    for (int k = 0; k < 8; k++) step(1, 0, 0);
    chk("pre_rst_qual", 32'(link_state), 32'd1);
    #5;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_state", 32'(link_state), 32'd0);
    chk("async_rst_rdy", 32'(rdy), 32'd0);
    chk("async_rst_wr_act", 32'(wr_act), 32'd0);
    chk("async_rst_rd_act", 32'(rd_act), 32'd0);
    chk("async_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    step(1, 1, 1);
    step(1, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < 25; k++) step(1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_aurora_link_status_monitor
